// File: rtl/decoder_scan_n_pkg.sv
// Shared types and decode helpers for decoder_scan_n.
package decoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIRECT = 2'd1,
    ST_SCAN   = 2'd2
  } state_e;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Helpers work at the widest supported size; callers cast down to their own width.
  localparam int MAX_SEL_W = 8;
  localparam int MAX_OUT_W = 2 ** MAX_SEL_W;

  function automatic logic [MAX_OUT_W-1:0] onehot(input logic [MAX_SEL_W-1:0] addr);
    logic [MAX_OUT_W-1:0] one;
    one = MAX_OUT_W'(1);
    return one << addr;
  endfunction

  function automatic logic [MAX_OUT_W-1:0] thermo(input logic [MAX_SEL_W-1:0] addr);
    logic [MAX_OUT_W-1:0] one;
    logic [MAX_SEL_W:0]   span;
    one  = MAX_OUT_W'(1);
    span = {1'b0, addr} + {{MAX_SEL_W{1'b0}}, 1'b1};
    return (one << span) - one;
  endfunction

endpackage

// File: rtl/decoder_scan_n_scan_timer.sv
// Dwell counter for scan mode: tick is high once the count has reached dwell.
module scan_timer #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic [DWELL_W-1:0] dwell,
  output logic               tick
);

  logic [DWELL_W-1:0] count_q;
  logic [DWELL_W-1:0] count_d;

  // dwell is compared live so a lowered value takes effect on the next edge
  assign tick = (count_q >= dwell);

  always_comb begin
    count_d = count_q;
    if (clear || tick) begin
      count_d = {DWELL_W{1'b0}};
    end else begin
      count_d = count_q + {{(DWELL_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= {DWELL_W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/decoder_scan_n.sv
// Registered N-to-2^N decoder with direct and self-timed scan modes.
// Optional thermometer output enabled by DECODER_SCAN_THERMO_EN.
module decoder_scan_n
  import decoder_pkg::*;
#(
  parameter int SEL_W   = 3,
  parameter int DWELL_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 mode,
  input  logic [SEL_W-1:0]     sel,
  input  logic                 sel_valid,
`ifdef DECODER_SCAN_THERMO_EN
  input  logic                 thermo,
`endif
  input  logic [DWELL_W-1:0]   dwell,
  output logic [2**SEL_W-1:0]  y,
  output logic [SEL_W-1:0]     cur_sel,
  output logic                 active,
  output logic                 wrap
);

  localparam int OUT_W = 2 ** SEL_W;

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   addr_q, addr_d;
  logic [OUT_W-1:0]   y_q, y_d;
  logic               active_q, active_d;
  logic               wrap_q, wrap_d;
  logic               th_s;
  logic               tick_s;
  logic               timer_clear_s;

`ifdef DECODER_SCAN_THERMO_EN
  assign th_s = thermo;
`else
  assign th_s = 1'b0;
`endif

  function automatic logic [OUT_W-1:0] decode(input logic [SEL_W-1:0] a, input logic th);
    return OUT_W'(th ? decoder_pkg::thermo(MAX_SEL_W'(a))
                     : decoder_pkg::onehot(MAX_SEL_W'(a)));
  endfunction

  // The timer only runs while scanning continues; any entry into scan restarts it.
  assign timer_clear_s = (state_q != ST_SCAN) || (state_d != ST_SCAN);

  scan_timer #(.DWELL_W(DWELL_W)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (timer_clear_s),
    .dwell (dwell),
    .tick  (tick_s)
  );

  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DIRECT, ST_SCAN: state_d = (mode == MODE_SCAN) ? ST_SCAN : ST_DIRECT;
        default:                     state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    addr_d = addr_q;
    y_d    = y_q;
    wrap_d = 1'b0;
    if (!enable) begin
      addr_d = {SEL_W{1'b0}};
      y_d    = {OUT_W{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE, ST_DIRECT: begin
          if (mode == MODE_SCAN) begin
            addr_d = {SEL_W{1'b0}};
            y_d    = decode({SEL_W{1'b0}}, th_s);
          end else if ((state_q == ST_DIRECT) && sel_valid) begin
            addr_d = sel;
            y_d    = decode(sel, th_s);
          end else begin
            addr_d = addr_q;
          end
        end
        ST_SCAN: begin
          // Leaving scan for direct keeps the last scanned address on the outputs
          if ((mode == MODE_SCAN) && tick_s) begin
            addr_d = addr_q + {{(SEL_W-1){1'b0}}, 1'b1};
            y_d    = decode(addr_d, th_s);
            wrap_d = &addr_q;
          end else begin
            addr_d = addr_q;
          end
        end
        default: begin
          addr_d = {SEL_W{1'b0}};
          y_d    = {OUT_W{1'b0}};
        end
      endcase
    end
    active_d = (y_d != {OUT_W{1'b0}});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      addr_q   <= {SEL_W{1'b0}};
      y_q      <= {OUT_W{1'b0}};
      active_q <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      y_q      <= y_d;
      active_q <= active_d;
      wrap_q   <= wrap_d;
    end
  end

  assign y       = y_q;
  assign cur_sel = addr_q;
  assign active  = active_q;
  assign wrap    = wrap_q;

endmodule

// File: tb/tb_decoder_scan_n.sv
// Randomised and directed checks of decoder_scan_n against a cycle-level reference model.
module tb_decoder_scan_n;

  localparam int SEL_W   = 3;
  localparam int DWELL_W = 8;
  localparam int OUT_W   = 8;

  logic               clk = 1'b0;
  logic               rst_n, enable, mode, sel_valid, thermo;
  logic [SEL_W-1:0]   sel;
  logic [DWELL_W-1:0] dwell;
  logic [OUT_W-1:0]   y;
  logic [SEL_W-1:0]   cur_sel;
  logic               active, wrap;

  int total = 0;
  int bad   = 0;

  // reference model state: 0 idle, 1 direct, 2 scan
  int m_st, m_addr, m_cnt, m_y, m_wrap;

  always #5 clk = ~clk;

  decoder_scan_n #(.SEL_W(SEL_W), .DWELL_W(DWELL_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .mode      (mode),
    .sel       (sel),
    .sel_valid (sel_valid),
`ifdef DECODER_SCAN_THERMO_EN
    .thermo    (thermo),
`endif
    .dwell     (dwell),
    .y         (y),
    .cur_sel   (cur_sel),
    .active    (active),
    .wrap      (wrap)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int ref_decode(input int a, input bit th);
    return th ? ((2 << a) - 1) : (1 << a);
  endfunction

  task automatic model_reset();
    m_st = 0; m_addr = 0; m_cnt = 0; m_y = 0; m_wrap = 0;
  endtask

  task automatic model_step();
    bit th;
    th = thermo;
    m_wrap = 0;
    if (!enable) begin
      model_reset();
    end else if (m_st == 2 && mode) begin
      if (m_cnt >= int'(dwell)) begin
        m_addr = (m_addr + 1) % OUT_W;
        m_cnt  = 0;
        m_y    = ref_decode(m_addr, th);
        m_wrap = (m_addr == 0);
      end else begin
        m_cnt++;
      end
    end else if (mode) begin
      m_st = 2; m_addr = 0; m_cnt = 0; m_y = ref_decode(0, th);
    end else begin
      if (m_st == 1 && sel_valid) begin
        m_addr = int'(sel);
        m_y    = ref_decode(m_addr, th);
      end
      m_st = 1;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".y"},      32'(y),       32'(m_y));
    check({tag, ".cur_sel"}, 32'(cur_sel), 32'(m_addr));
    check({tag, ".active"}, 32'(active),  32'(m_y != 0));
    check({tag, ".wrap"},   32'(wrap),    32'(m_wrap));
  endtask

  task automatic cyc(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  initial begin
    int prev;
    rst_n = 1'b0; enable = 1'b0; mode = 1'b0; sel = 3'd0; sel_valid = 1'b0;
    thermo = 1'b0; dwell = 8'd0;
    model_reset();
    #12;
    check("rst.y", 32'(y), 32'd0);
    check("rst.active", 32'(active), 32'd0);
    check("rst.wrap", 32'(wrap), 32'd0);
    @(negedge clk) rst_n = 1'b1;

    // direct decode of address 5 and hold
    enable = 1'b1; mode = 1'b0;
    cyc("dir_entry");
    sel = 3'd5; sel_valid = 1'b1;
    cyc("dir_load");
    check("dir_sel5", 32'(y), 32'h20);
    sel = 3'd2; sel_valid = 1'b0;
    cyc("dir_hold");
    check("dir_hold_y", 32'(y), 32'h20);

    // fast scan: one step per cycle, wrap on the return to 0
    mode = 1'b1; dwell = 8'd0;
    cyc("scan_entry");
    check("scan_entry_y", 32'(y), 32'h01);
    for (int i = 0; i < 8; i++) begin
      cyc("scan_fast");
      check("scan_wrap", 32'(wrap), 32'(i == 7));
    end

    // dwell 3 holds four cycles; dropping dwell advances immediately
    enable = 1'b0;
    cyc("scan_off");
    enable = 1'b1; dwell = 8'd3;
    cyc("dwell_entry");
    for (int i = 0; i < 4; i++) cyc("dwell3");
    check("dwell3_y", 32'(y), 32'h02);
    cyc("dwell3_mid");
    prev = int'(cur_sel);
    dwell = 8'd0;
    cyc("dwell_drop");
    check("dwell_drop_sel", 32'(cur_sel), 32'((prev + 1) % OUT_W));

    // scan to address 6, switch to direct, then load address 1
    for (int i = 0; i < 4; i++) cyc("to_six");
    check("six_y", 32'(y), 32'h40);
    mode = 1'b0;
    cyc("scan_to_dir");
    check("scan_to_dir_y", 32'(y), 32'h40);
    sel = 3'd1; sel_valid = 1'b1;
    cyc("dir_after_scan");
    check("dir_after_scan_y", 32'(y), 32'h02);
    sel_valid = 1'b0;

    // disable mid-scan, re-enable restarts at 0 without wrap
    mode = 1'b1;
    cyc("rescan"); cyc("rescan"); cyc("rescan");
    enable = 1'b0;
    cyc("disable");
    check("disable_active", 32'(active), 32'd0);
    enable = 1'b1;
    cyc("reenable");
    check("reenable_wrap", 32'(wrap), 32'd0);

    // asynchronous reset mid-scan
    cyc("pre_arst");
    rst_n = 1'b0;
    #1;
    model_reset();
    check("arst_y", 32'(y), 32'd0);
    check("arst_active", 32'(active), 32'd0);
    check("arst_sel", 32'(cur_sel), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    cyc("post_arst");
    check("post_arst_y", 32'(y), 32'h01);

`ifdef DECODER_SCAN_THERMO_EN
    mode = 1'b0;
    cyc("th_dir");
    thermo = 1'b1; sel = 3'd3; sel_valid = 1'b1;
    cyc("th_load");
    check("thermo_sel3", 32'(y), 32'h0F);
    thermo = 1'b0; sel_valid = 1'b0;
`endif

    // randomised traffic
    for (int i = 0; i < 600; i++) begin
      enable    = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 7) == 0) mode = ~mode;
      sel       = SEL_W'($urandom_range(0, OUT_W - 1));
      sel_valid = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 9) == 0) dwell = DWELL_W'($urandom_range(0, 3));
`ifdef DECODER_SCAN_THERMO_EN
      thermo    = $urandom_range(0, 1) == 1;
`endif
      cyc("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
